pipe_ctrl: RTL

Central pipeline controller for the 5-stage MIPS core. It gathers stall requests from the IF/ID/EX/MEM stages and exception/ERET events from MEM. It produces the per-stage stall vector, the per-stage flush strobes, and the redirect target (flush_pc) consumed by the PC/IF stage. A small FSM defers the PC redirect while an instruction-SRAM fetch is still outstanding. Stall and flush event counters are kept for debug.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_ctrl_dffre.sv | 18 +
 rtl/pipe_ctrl_stall_encode.sv | 21 ++
 rtl/pipe_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared stage indices, stall-vector width, exception vector default and FSM encoding.
// Latency: n/a; backpressure: n/a.
package pipe_ctrl_pkg;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;
  localparam int STALL_W = STG_WB + 1;

  localparam logic [31:0] EXC_VEC_DEF = 32'hbfc00380;

  typedef enum logic {
    RUN        = 1'b0,
    FLUSH_WAIT = 1'b1
  } state_t;

  // Mask with stall bits from the PC stage up to and including stage k.
  function automatic logic [STALL_W-1:0] stall_upto(input int k);
    return STALL_W'((7'd1 << (k + 1)) - (7'd1 << STG_PC));
  endfunction

endpackage

// File: rtl/pipe_ctrl_dffre.sv
// Enable flop with async active-low clear to zero.
// Latency: 1 cycle; backpressure: none (en gates the update).
module dffre #(
  parameter int W = 1
) (
  input  logic         core_clk,
  input  logic         arst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_ctrl_stall_encode.sv
// Oldest-requester-wins stall priority encoder: stages PC..k stall.
// Latency: 0 cycles (combinational); backpressure: output is the backpressure.
module stall_encode
  import pipe_ctrl_pkg::*;
(
  input  logic               if_req,
  input  logic               id_req,
  input  logic               ex_req,
  input  logic               mem_req,
  output logic [STALL_W-1:0] stall
);

  always_comb begin
    stall = '0;
    if (mem_req)     stall = stall_upto(STG_MEM);
    else if (ex_req) stall = stall_upto(STG_EX);
    else if (id_req) stall = stall_upto(STG_ID);
    else if (if_req) stall = stall_upto(STG_IF);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall vector, flush strobes, redirect target, debug counters.
// Latency: 0 cycles for stall/flush; redirect deferred while a fetch is outstanding.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF,
  parameter int          CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_stallreq_i,
  input  logic             id_stallreq_i,
  input  logic             ex_stallreq_i,
  input  logic             mem_stallreq_i,
  input  logic             mem_exc_i,
  input  logic             mem_eret_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall_o,
  output logic             pc_flush_o,
  output logic             if_flush_o,
  output logic             id_flush_o,
  output logic             ex_flush_o,
  output logic             mem_flush_o,
  output logic [31:0]      flush_pc_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_t             state_q, state_d;
  logic [STALL_W-1:0] enc_stall;
  logic [31:0]        pend_pc_q;
  logic [31:0]        target;
  logic               evt;
  logic               pend_en;
  logic               flush_inc;

  stall_encode u_stall_encode (
    .if_req  (if_stallreq_i),
    .id_req  (id_stallreq_i),
    .ex_req  (ex_stallreq_i),
    .mem_req (mem_stallreq_i),
    .stall   (enc_stall)
  );

  // A MEM event is only acted on once MEM itself is no longer stalled.
  assign target = mem_exc_i ? EXC_VEC : cp0_epc_i;
  assign evt    = (state_q == RUN) & (mem_exc_i | mem_eret_i) & ~mem_stallreq_i;

  always_comb begin
    stall_o     = '0;
    pc_flush_o  = 1'b0;
    if_flush_o  = 1'b0;
    id_flush_o  = 1'b0;
    ex_flush_o  = 1'b0;
    mem_flush_o = 1'b0;
    flush_pc_o  = '0;
    busy_o      = 1'b0;
    pend_en     = 1'b0;
    flush_inc   = 1'b0;
    state_d     = state_q;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (evt) begin
            id_flush_o  = 1'b1;
            ex_flush_o  = 1'b1;
            mem_flush_o = 1'b1;
            if (if_stallreq_i) begin
              stall_o = stall_upto(STG_IF);
              pend_en = 1'b1;
              state_d = FLUSH_WAIT;
            end else begin
              pc_flush_o = 1'b1;
              if_flush_o = 1'b1;
              flush_pc_o = target;
              flush_inc  = 1'b1;
            end
          end else begin
            stall_o = enc_stall;
          end
        end
        FLUSH_WAIT: begin
          // Younger stages already hold bubbles; only the fetch is tracked here.
          busy_o     = 1'b1;
          flush_pc_o = pend_pc_q;
          if_flush_o = 1'b1;
          if (if_stallreq_i) begin
            stall_o = stall_upto(STG_IF);
          end else begin
            pc_flush_o = 1'b1;
            flush_inc  = 1'b1;
            state_d    = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  dffre #(.W(32)) u_pend_pc (
    .core_clk (clk),
    .arst_n   (~rst),
    .en       (pend_en),
    .d        (target),
    .q        (pend_pc_q)
  );

  dffre #(.W(CNT_W)) u_stall_cnt (
    .core_clk (clk),
    .arst_n   (~rst),
    .en       (|stall_o),
    .d        (stall_cnt_o + CNT_W'(1)),
    .q        (stall_cnt_o)
  );

  dffre #(.W(CNT_W)) u_flush_cnt (
    .core_clk (clk),
    .arst_n   (~rst),
    .en       (flush_inc),
    .d        (flush_cnt_o + CNT_W'(1)),
    .q        (flush_cnt_o)
  );

endmodule
